// File: rtl/fifo_pkg.sv
// Shared FSM encoding and default sizing for the FIFO access scheduler.
package fifo_pkg;

   localparam int DEF_DATA_WIDTH     = 4;
   localparam int DEF_FIFO_DEPTH     = 16;
   localparam int DEF_PIPELINE_DEPTH = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACTIVE,
      S_FLUSH,
      S_WAIT_PIPE
   } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer moves to the other writer after every grant.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] grant_o
);

   logic ptr_q, ptr_d;

   always_comb begin
      grant_o = 2'b00;
      if (en_i) begin
         case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
         endcase
      end
      ptr_d = ptr_q;
      if (grant_o[0]) begin
         ptr_d = 1'b1;
      end else if (grant_o[1]) begin
         ptr_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/fifo_access_scheduler.sv
// Arbitrates two writers and one reader onto an external FIFO with a fixed read latency,
// tracks occupancy, and drains the FIFO on request.
module fifo_access_scheduler
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
   parameter int PIPELINE_DEPTH = DEF_PIPELINE_DEPTH
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [1:0]                        wr_valid,
   input  logic [DATA_WIDTH-1:0]             wr_data0,
   input  logic [DATA_WIDTH-1:0]             wr_data1,
   output logic [1:0]                        wr_ready,
   input  logic                              rd_req,
   output logic                              rd_valid,
   output logic [DATA_WIDTH-1:0]             rd_data,
   input  logic                              flush,
   output logic                              flush_done,
   output logic                              busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
   output logic                              fifo_write_en,
   output logic [DATA_WIDTH-1:0]             fifo_data_in,
   output logic                              fifo_read_en,
   input  logic                              fifo_full,
   input  logic                              fifo_empty,
   input  logic [DATA_WIDTH-1:0]             fifo_data_out
);

   localparam int LW = $clog2(FIFO_DEPTH+1);

   state_e                    state_q, state_d;
   logic [PIPELINE_DEPTH-1:0] vld_q, vld_d, vld_shift;
   logic [LW-1:0]             level_q, level_d;
   logic [1:0]                grant;
   logic                      ctrl_open, wr_fire, rd_fire;

   function automatic logic [LW-1:0] sat_level(input logic [LW-1:0] lvl,
                                               input logic inc, input logic dec);
      logic [LW-1:0] r;
      r = lvl;
      if (inc && !dec && lvl != LW'(FIFO_DEPTH)) begin
         r = lvl + LW'(1);
      end else if (dec && !inc && lvl != '0) begin
         r = lvl - LW'(1);
      end
      return r;
   endfunction

   // Writes and consumer reads are only serviced outside of a drain.
   assign ctrl_open = !rst && (state_q == S_IDLE || state_q == S_ACTIVE);

   rr_arbiter2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .en_i    (ctrl_open && !fifo_full),
      .req_i   (wr_valid),
      .grant_o (grant)
   );

   assign wr_ready      = grant;
   assign wr_fire       = |grant;
   assign fifo_write_en = wr_fire;
   assign fifo_data_in  = grant[1] ? wr_data1 : (grant[0] ? wr_data0 : '0);

   assign rd_fire      = !rst && !fifo_empty && ((ctrl_open && rd_req) || state_q == S_FLUSH);
   assign fifo_read_en = rd_fire;

   assign rd_valid = vld_q[PIPELINE_DEPTH-1];
   assign rd_data  = rd_valid ? fifo_data_out : '0;
   assign busy     = (state_q != S_IDLE);
   assign level    = level_q;

   assign vld_shift = vld_q << 1;

   always_comb begin
      vld_d    = vld_shift;
      vld_d[0] = rd_fire;
      level_d  = sat_level(level_q, wr_fire, rd_fire);
   end

   always_comb begin
      state_d    = state_q;
      flush_done = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (flush) begin
               state_d = S_FLUSH;
            end else if (|wr_valid || rd_req) begin
               state_d = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            if (flush) begin
               state_d = S_FLUSH;
            end else if (!(|wr_valid) && !rd_req && level_q == '0 && vld_q == '0) begin
               state_d = S_IDLE;
            end
         end
         S_FLUSH: begin
            if (fifo_empty) begin
               state_d = S_WAIT_PIPE;
            end
         end
         S_WAIT_PIPE: begin
            // No reads enter here, so completion lands in the cycle the last word leaves.
            if (vld_shift == '0) begin
               flush_done = !rst;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         vld_q   <= '0;
         level_q <= '0;
      end else begin
         state_q <= state_d;
         vld_q   <= vld_d;
         level_q <= level_d;
      end
   end

endmodule

// File: tb/tb_fifo_access_scheduler.sv
// Directed bench for fifo_access_scheduler with a delayed-read FIFO model and a data scoreboard.
module tb_fifo_access_scheduler;
   import fifo_pkg::*;

   localparam int DW    = 4;
   localparam int DEPTH = 16;
   localparam int PD    = 4;
   localparam int LW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    wr_valid;
   logic [DW-1:0] wr_data0, wr_data1;
   logic [1:0]    wr_ready;
   logic          rd_req, rd_valid;
   logic [DW-1:0] rd_data;
   logic          flush, flush_done, busy;
   logic [LW-1:0] level;
   logic          fifo_write_en, fifo_read_en, fifo_full, fifo_empty;
   logic [DW-1:0] fifo_data_in, fifo_data_out;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int last_rd_cyc = -1;
   int rv_cnt = 0;
   int cnt = 0;
   int rv0;

   logic [DW-1:0] sb[$];
   logic [DW-1:0] mem[$];
   logic [DW:0]   dline[PD];

   always #5 clk = ~clk;

   fifo_access_scheduler #(
      .DATA_WIDTH     (DW),
      .FIFO_DEPTH     (DEPTH),
      .PIPELINE_DEPTH (PD)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .wr_valid      (wr_valid),
      .wr_data0      (wr_data0),
      .wr_data1      (wr_data1),
      .wr_ready      (wr_ready),
      .rd_req        (rd_req),
      .rd_valid      (rd_valid),
      .rd_data       (rd_data),
      .flush         (flush),
      .flush_done    (flush_done),
      .busy          (busy),
      .level         (level),
      .fifo_write_en (fifo_write_en),
      .fifo_data_in  (fifo_data_in),
      .fifo_read_en  (fifo_read_en),
      .fifo_full     (fifo_full),
      .fifo_empty    (fifo_empty),
      .fifo_data_out (fifo_data_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // FIFO model: read data appears PD cycles after the read, junk otherwise.
   assign fifo_full     = (cnt >= DEPTH);
   assign fifo_empty    = (cnt == 0);
   assign fifo_data_out = dline[PD-1][DW] ? dline[PD-1][DW-1:0] : DW'(12);

   initial begin
      logic [DW:0] head;
      for (int i = 0; i < PD; i++) dline[i] = '0;
      forever begin
         @(posedge clk);
         cyc <= cyc + 1;
         if (rst) begin
            mem.delete();
            cnt <= 0;
            for (int i = 0; i < PD; i++) dline[i] <= '0;
         end else begin
            head = '0;
            if (fifo_read_en && mem.size() > 0) head = {1'b1, mem.pop_front()};
            if (fifo_write_en) mem.push_back(fifo_data_in);
            cnt <= mem.size();
            dline[0] <= head;
            for (int i = 1; i < PD; i++) dline[i] <= dline[i-1];
         end
      end
   end

   // Output monitor: pops the scoreboard on each returned word.
   initial begin
      logic [DW-1:0] e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (fifo_read_en) last_rd_cyc = cyc;
            if (rd_valid) begin
               rv_cnt++;
               if (sb.size() == 0) begin
                  chk("rd_unexpected", 32'(rd_valid), 32'(0));
               end else begin
                  e = sb.pop_front();
                  chk("rd_data", 32'(rd_data), 32'(e));
               end
            end else begin
               chk("rd_data_idle", 32'(rd_data), 32'(0));
            end
            chk("no_wr_when_full", 32'(fifo_write_en & fifo_full), 32'(0));
            chk("no_rd_when_empty", 32'(fifo_read_en & fifo_empty), 32'(0));
         end
      end
   end

   task automatic wait_flush(input string tag);
      int fd;
      fd = -1;
      for (int k = 0; k < 20 && fd < 0; k++) begin
         @(negedge clk);
         if (flush_done) fd = cyc;
      end
      chk(tag, 32'(fd - last_rd_cyc), 32'(4));
      nxt();
      @(negedge clk);
      chk("flush_done_pulse", 32'(flush_done), 32'(0));
      chk("flush_end_busy", 32'(busy), 32'(0));
      chk("flush_end_level", 32'(level), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; wr_valid = '0; wr_data0 = '0; wr_data1 = '0; rd_req = 1'b0; flush = 1'b0;
      nxt();
      wr_valid = 2'b11; rd_req = 1'b1; flush = 1'b1; wr_data0 = 4'h1; wr_data1 = 4'h2;
      @(negedge clk);
      chk("rst_wr_ready", 32'(wr_ready), 32'(0));
      chk("rst_write_en", 32'(fifo_write_en), 32'(0));
      chk("rst_data_in", 32'(fifo_data_in), 32'(0));
      chk("rst_read_en", 32'(fifo_read_en), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_level", 32'(level), 32'(0));
      chk("rst_rd_valid", 32'(rd_valid), 32'(0));
      chk("rst_flush_done", 32'(flush_done), 32'(0));
      nxt();
      rst = 1'b0; wr_valid = '0; rd_req = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'(0));
      chk("idle_level", 32'(level), 32'(0));

      // Two writers contending
      nxt();
      wr_data0 = 4'hA; wr_data1 = 4'h5; wr_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         logic [1:0]    eg;
         logic [DW-1:0] ed;
         eg = (k % 2 == 0) ? 2'b01 : 2'b10;
         ed = (k % 2 == 0) ? 4'hA : 4'h5;
         @(negedge clk);
         chk("rr_grant", 32'(wr_ready), 32'(eg));
         chk("rr_data_in", 32'(fifo_data_in), 32'(ed));
         sb.push_back(ed);
         nxt();
      end
      wr_valid = '0;
      @(negedge clk);
      chk("rr_level", 32'(level), 32'(4));
      chk("rr_busy", 32'(busy), 32'(1));

      // Single requester, then simultaneous read and write
      nxt();
      wr_valid = 2'b10; wr_data1 = 4'h7;
      @(negedge clk);
      chk("single_req1", 32'(wr_ready), 32'(2'b10));
      sb.push_back(4'h7);
      nxt();
      wr_valid = 2'b01; wr_data0 = 4'h9; rd_req = 1'b1;
      @(negedge clk);
      chk("wr_rd_grant", 32'(wr_ready), 32'(2'b01));
      chk("wr_rd_read_en", 32'(fifo_read_en), 32'(1));
      chk("wr_rd_level_pre", 32'(level), 32'(5));
      sb.push_back(4'h9);
      nxt();
      wr_valid = '0; rd_req = 1'b0;
      @(negedge clk);
      chk("wr_rd_level_hold", 32'(level), 32'(5));

      // Bring level to 3, then flush
      nxt();
      rd_req = 1'b1;
      nxt();
      nxt();
      rd_req = 1'b0;
      repeat (6) @(negedge clk);
      chk("pre_flush_level", 32'(level), 32'(3));
      rv0 = rv_cnt;
      nxt();
      flush = 1'b1;
      @(negedge clk);
      nxt();
      flush = 1'b0; wr_valid = 2'b01; wr_data0 = 4'hE;
      @(negedge clk);
      chk("flush_blocks_write", 32'(wr_ready), 32'(0));
      chk("flush_read_en", 32'(fifo_read_en), 32'(1));
      chk("flush_busy", 32'(busy), 32'(1));
      nxt();
      wr_valid = '0;
      wait_flush("flush_done_latency");
      chk("flush_rd_valid_count", 32'(rv_cnt - rv0), 32'(3));

      // Flush in the same cycle as a write
      nxt();
      wr_valid = 2'b01; wr_data0 = 4'h6; flush = 1'b1;
      @(negedge clk);
      chk("flush_wr_grant", 32'(wr_ready), 32'(2'b01));
      chk("flush_wr_en", 32'(fifo_write_en), 32'(1));
      sb.push_back(4'h6);
      nxt();
      wr_valid = '0; flush = 1'b0;
      @(negedge clk);
      chk("flush_wr_busy", 32'(busy), 32'(1));
      chk("flush_wr_level", 32'(level), 32'(1));
      chk("flush_wr_read_en", 32'(fifo_read_en), 32'(1));
      wait_flush("flush2_done_latency");

      // Fill to full, then drain past empty
      nxt();
      wr_valid = 2'b01;
      for (int k = 0; k < DEPTH; k++) begin
         wr_data0 = DW'(k);
         @(negedge clk);
         chk("fill_grant", 32'(wr_ready), 32'(2'b01));
         sb.push_back(DW'(k));
         nxt();
      end
      wr_valid = 2'b11;
      @(negedge clk);
      chk("full_no_grant", 32'(wr_ready), 32'(0));
      chk("full_no_write", 32'(fifo_write_en), 32'(0));
      chk("full_level", 32'(level), 32'(16));
      nxt();
      @(negedge clk);
      chk("full_level_hold", 32'(level), 32'(16));
      nxt();
      wr_valid = '0; rd_req = 1'b1;
      for (int k = 0; k <= DEPTH; k++) begin
         @(negedge clk);
         chk("drain_read_en", 32'(fifo_read_en), 32'(k < DEPTH));
         nxt();
      end
      rd_req = 1'b0;
      @(negedge clk);
      chk("drain_level", 32'(level), 32'(0));
      repeat (8) @(negedge clk);
      chk("drain_busy", 32'(busy), 32'(0));
      chk("drain_sb_empty", 32'(sb.size()), 32'(0));

      // Single read latency
      nxt();
      wr_valid = 2'b01; wr_data0 = 4'h3;
      @(negedge clk);
      sb.push_back(4'h3);
      nxt();
      wr_valid = '0; rd_req = 1'b1;
      @(negedge clk);
      chk("single_rd_en", 32'(fifo_read_en), 32'(1));
      nxt();
      rd_req = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         chk("rd_latency", 32'(rd_valid), 32'(k == 4));
      end

      // Reset two cycles after a read
      nxt();
      wr_valid = 2'b01; wr_data0 = 4'h8;
      @(negedge clk);
      sb.push_back(4'h8);
      nxt();
      wr_valid = '0; rd_req = 1'b1;
      nxt();
      rd_req = 1'b0;
      nxt();
      rst = 1'b1;
      nxt();
      @(negedge clk);
      sb.delete();
      chk("mid_rst_rd_valid", 32'(rd_valid), 32'(0));
      chk("mid_rst_rd_data", 32'(rd_data), 32'(0));
      chk("mid_rst_busy", 32'(busy), 32'(0));
      chk("mid_rst_level", 32'(level), 32'(0));
      chk("mid_rst_flush_done", 32'(flush_done), 32'(0));
      chk("mid_rst_wr_ready", 32'(wr_ready), 32'(0));
      chk("mid_rst_fifo_ctl", 32'({fifo_write_en, fifo_read_en}), 32'(0));
      chk("mid_rst_data_in", 32'(fifo_data_in), 32'(0));
      nxt();
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("post_rst_no_valid", 32'(rd_valid), 32'(0));
      end
      chk("post_rst_busy", 32'(busy), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
